// File: rtl/imm_materializer.sv
// Splits a 64-bit constant into an RV64I ADDI / LUI / LUI+ADDIW load sequence
// and emits one encoded instruction word per output handshake.
module imm_materializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] imm_in,
    input  logic [4:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic        out_last,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        EMIT_ADDI,
        EMIT_LUI,
        EMIT_ADDIW,
        ERR
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

    state_t      state;
    state_t      state_d;
    logic        accept;
    logic        fits12;
    logic        fits32;
    logic [11:0] lo12_in;
    logic [19:0] hi20_in;
    logic [11:0] lo12_q;
    logic [11:0] lo12_d;
    logic [19:0] hi20_q;
    logic [19:0] hi20_d;
    logic [4:0]  rd_q;
    logic [4:0]  rd_d;
    logic [31:0] instr_d;
    logic        last_d;
    logic        valid_d;
    logic        err_d;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    assign fits12  = (&imm_in[63:11]) || !(|imm_in[63:11]);
    assign fits32  = (&imm_in[63:31]) || !(|imm_in[63:31]);
    assign lo12_in = imm_in[11:0];
    // Rounding add of 0x800 only carries into the upper field via bit 11;
    // wraps to 0x80000 near 2^31-1, which the sign-extending ADDIW undoes.
    assign hi20_in = imm_in[31:12] + {19'd0, imm_in[11]};

    // Output registers are loaded from the next state and the next captured
    // fields, so a stalled word is simply recomputed from unchanged inputs.
    assign lo12_d = accept ? lo12_in : lo12_q;
    assign hi20_d = accept ? hi20_in : hi20_q;
    assign rd_d   = accept ? rd      : rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lo12_q    <= '0;
            hi20_q    <= '0;
            rd_q      <= '0;
            instr_out <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            lo12_q    <= lo12_d;
            hi20_q    <= hi20_d;
            rd_q      <= rd_d;
            instr_out <= instr_d;
            out_last  <= last_d;
            out_valid <= valid_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fits12)      state_d = EMIT_ADDI;
                    else if (fits32) state_d = EMIT_LUI;
                    else             state_d = ERR;
                end
            end
            EMIT_ADDI: begin
                if (out_ready) state_d = IDLE;
            end
            EMIT_LUI: begin
                if (out_ready) state_d = (lo12_q != 12'd0) ? EMIT_ADDIW : IDLE;
            end
            EMIT_ADDIW: begin
                if (out_ready) state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        instr_d = '0;
        last_d  = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_d)
            EMIT_ADDI: begin
                instr_d = {lo12_d, 5'd0, 3'b000, rd_d, OP_IMM};
                last_d  = 1'b1;
                valid_d = 1'b1;
            end
            EMIT_LUI: begin
                instr_d = {hi20_d, rd_d, OP_LUI};
                last_d  = (lo12_d == 12'd0);
                valid_d = 1'b1;
            end
            EMIT_ADDIW: begin
                instr_d = {lo12_d, rd_d, 3'b000, rd_d, OP_IMM_32};
                last_d  = 1'b1;
                valid_d = 1'b1;
            end
            ERR: begin
                err_d = 1'b1;
            end
            default: begin
                instr_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_imm_materializer.sv
// Directed bench for imm_materializer: hand-computed instruction words,
// stall stability, error pulse timing and mid-sequence reset.
module tb_imm_materializer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] imm_in;
    logic [4:0]  rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic        out_last;
    logic        err;

    int checks = 0;
    int errors = 0;

    imm_materializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_in    (imm_in),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_out (instr_out),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full output snapshot, sampled on the falling edge.
    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic last, input logic e, input logic rdy);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".instr_out"}, instr_out, ins);
        chk({tag, ".out_last"},  {31'd0, out_last},  {31'd0, last});
        chk({tag, ".err"},       {31'd0, err},       {31'd0, e});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
    endtask

    // Present one request for exactly one rising edge; returns at the next falling edge.
    task automatic req(input logic [63:0] val, input logic [4:0] r);
        imm_in   = val;
        rd       = r;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        imm_in   = 64'hDEAD_BEEF_DEAD_BEEF;
        rd       = 5'd31;
        @(negedge clk);
    endtask

    // Complete a handshake on the current word; returns at the next falling edge.
    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        imm_in    = '0;
        rd        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk_out("idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Small positive value: single ADDI
        req(64'd5, 5'd10);
        chk_out("addi5", 1'b1, 32'h0050_0513, 1'b1, 1'b0, 1'b0);
        take();
        chk_out("addi5_done", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // All-ones: ADDI with lo12 = 0xFFF
        req(64'hFFFF_FFFF_FFFF_FFFF, 5'd3);
        chk_out("addi_m1", 1'b1, 32'hFFF0_0193, 1'b1, 1'b0, 1'b0);
        take();
        chk_out("addi_m1_done", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Two-word sequence with a 3-cycle stall on the first word
        req(64'h0000_0000_1234_5678, 5'd5);
        chk_out("lui_stall0", 1'b1, 32'h1234_52B7, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk_out($sformatf("lui_stall%0d", i), 1'b1, 32'h1234_52B7, 1'b0, 1'b0, 1'b0);
        end
        take();
        chk_out("addiw_678", 1'b1, 32'h6782_829B, 1'b1, 1'b0, 1'b0);
        take();
        chk_out("seq_678_done", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // hi20 wrap case, out_ready held high across both words (no bubble)
        req(64'h0000_0000_7FFF_FFFF, 5'd1);
        chk_out("lui_wrap", 1'b1, 32'h8000_00B7, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("addiw_wrap", 1'b1, 32'hFFF0_809B, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        chk_out("wrap_done", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // LUI alone when lo12 is zero
        req(64'h0000_0000_0000_1000, 5'd2);
        chk_out("lui_only", 1'b1, 32'h0000_1137, 1'b1, 1'b0, 1'b0);
        take();
        chk_out("lui_only_done", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Negative 32-bit value: 0xFFFFFFFF80000000 -> LUI 0x80000 only
        req(64'hFFFF_FFFF_8000_0000, 5'd7);
        chk_out("lui_neg", 1'b1, 32'h8000_03B7, 1'b1, 1'b0, 1'b0);
        take();

        // Unrepresentable constant: one-cycle err, no output word
        req(64'h0000_0001_0000_0000, 5'd4);
        chk_out("err_pulse", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("err_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // out_ready while idle has no effect
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_out("ready_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset while the first word is stalled drops the sequence
        req(64'h0000_0000_1234_5678, 5'd5);
        chk_out("pre_reset", 1'b1, 32'h1234_52B7, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_out("mid_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        req(64'd5, 5'd10);
        chk_out("post_reset", 1'b1, 32'h0050_0513, 1'b1, 1'b0, 1'b0);
        take();
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("post_reset_idle%0d", i), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
